// File: rtl/direct_bounded_differentiator_if.sv
// Stream bundle for the bounded differentiator: input windowed sums and
// reconstructed output samples, each with a valid/ready handshake.
interface direct_bounded_differentiator_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 17
);
  localparam int unsigned IWIDTH = WIDTH + $clog2(SIZE + 1);

  logic [IWIDTH-1:0] i_tdata;
  logic              i_tvalid;
  logic              i_tready;
  logic [WIDTH-1:0]  o_tdata;
  logic              o_tvalid;
  logic              o_tready;

  // Producer of sums / consumer of samples
  modport master (
    output i_tdata, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tvalid
  );

  // The differentiator itself
  modport slave (
    input  i_tdata, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tvalid
  );
endinterface

// File: rtl/direct_bounded_differentiator.sv
// Inverts a length-SIZE moving-sum integrator: x[n] = y[n] - y[n-1] + x[n-SIZE].
// All arithmetic wraps at IWIDTH bits; the history keeps full-width results so
// an out-of-range output never corrupts later samples.
module direct_bounded_differentiator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 17
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  direct_bounded_differentiator_if.slave s,
  output logic                          range_err
);
  localparam int unsigned IWIDTH = WIDTH + $clog2(SIZE + 1);
  localparam int unsigned TOPW   = IWIDTH - WIDTH + 1;

  // hist[0] is x[n-1], hist[SIZE-1] is x[n-SIZE]
  logic [SIZE-1:0][IWIDTH-1:0] hist;
  logic [IWIDTH-1:0]           y_prev;

  logic              xfer_c;
  logic [IWIDTH-1:0] result_c;
  logic [TOPW-1:0]   top_c;
  logic              ovf_c;

  // Single output stage: accept whenever the stage is empty or draining
  assign s.i_tready = ~s.o_tvalid | s.o_tready;

  // Next result and its range check
  always_comb begin
    xfer_c   = s.i_tvalid & s.i_tready;
    result_c = s.i_tdata - y_prev + hist[SIZE-1];
    top_c    = result_c[IWIDTH-1:WIDTH-1];
    ovf_c    = ~((&top_c) | ~(|top_c));
  end

  // History, previous input, output stage and sticky range flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist       <= '0;
      y_prev     <= '0;
      s.o_tdata  <= '0;
      s.o_tvalid <= 1'b0;
      range_err  <= 1'b0;
    end else if (clear) begin
      hist       <= '0;
      y_prev     <= '0;
      s.o_tdata  <= '0;
      s.o_tvalid <= 1'b0;
      range_err  <= 1'b0;
    end else if (xfer_c) begin
      hist       <= {hist[SIZE-2:0], result_c};
      y_prev     <= s.i_tdata;
      s.o_tdata  <= result_c[WIDTH-1:0];
      s.o_tvalid <= 1'b1;
      range_err  <= range_err | ovf_c;
    end else if (s.o_tready) begin
      s.o_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_direct_bounded_differentiator.sv
// Scoreboard bench: driver feeds sums and pushes expected samples computed
// from the full-sequence definition; monitor pops on every output handshake.
module tb_direct_bounded_differentiator;
  localparam int WIDTH = 16;
  localparam int SIZE  = 17;
  localparam int IW    = 21;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic range_err;

  direct_bounded_differentiator_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  direct_bounded_differentiator #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .s         (bus),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the whole reconstructed sequence since the last reset/clear
  logic [IW-1:0]  m_xs[$];
  logic [IW-1:0]  m_yprev;
  logic           m_err;
  logic [WIDTH:0] expq[$];
  int             tb_x[$];
  int             ready_pct = 100;
  logic           last_xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_xs.delete();
    m_yprev = '0;
    m_err   = 1'b0;
    expq.delete();
  endfunction

  function automatic void model_push(input logic [IW-1:0] y);
    int n = m_xs.size();
    logic [IW-1:0] xold;
    logic [IW-1:0] x;
    logic signed [IW-1:0] xsg;
    xold = (n >= SIZE) ? m_xs[n-SIZE] : '0;
    x    = y - m_yprev + xold;
    m_xs.push_back(x);
    m_yprev = y;
    xsg = x;
    if (xsg < -32768 || xsg > 32767) m_err = 1'b1;
    expq.push_back({m_err, x[WIDTH-1:0]});
  endfunction

  // Moving-sum integrator used to build sums from desired samples
  function automatic logic [IW-1:0] integ(input int x);
    longint s = 0;
    tb_x.push_back(x);
    for (int i = 0; i < SIZE && i < tb_x.size(); i++) s += tb_x[tb_x.size()-1-i];
    return IW'(s);
  endfunction

  function automatic logic ready_gen();
    return ($urandom_range(0, 99) < ready_pct);
  endfunction

  task automatic cycle(input logic v, input logic [IW-1:0] y, input logic rdy, input logic clr);
    @(negedge clk);
    bus.i_tvalid = v;
    bus.i_tdata  = y;
    bus.o_tready = rdy;
    clear        = clr;
    #1;
    last_xfer = v && bus.i_tready && !clr;
    if (clr) begin
      @(posedge clk);
      #1;
      clear        = 1'b0;
      bus.i_tvalid = 1'b0;
      model_reset();
      tb_x.delete();
      chk("clear_o_tvalid", 32'(bus.o_tvalid), 32'd0);
      chk("clear_range_err", 32'(range_err), 32'd0);
      chk("clear_o_tdata", 32'(bus.o_tdata), 32'd0);
      chk("clear_i_tready", 32'(bus.i_tready), 32'd1);
    end else if (last_xfer) begin
      model_push(y);
    end
  endtask

  task automatic send(input logic [IW-1:0] y);
    int guard = 0;
    do begin
      cycle(1'b1, y, ready_gen(), 1'b0);
      guard++;
    end while (!last_xfer && guard < 200);
    if (!last_xfer) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_o_tvalid", 32'(bus.o_tvalid), 32'd0);
    chk("async_o_tdata", 32'(bus.o_tdata), 32'd0);
    chk("async_range_err", 32'(range_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tb_x.delete();
    chk("async_i_tready", 32'(bus.i_tready), 32'd1);
  endtask

  // Monitor: compare every delivered sample, and check stalls hold stable
  initial begin
    logic           stall_prev;
    logic [WIDTH-1:0] held;
    logic [WIDTH:0] e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stall_prev = 1'b0;
      end else if (bus.o_tvalid && bus.o_tready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", bus.o_tdata);
        end else begin
          e = expq.pop_front();
          chk("o_tdata", 32'(bus.o_tdata), 32'(e[WIDTH-1:0]));
          chk("range_err", 32'(range_err), 32'(e[WIDTH]));
        end
        stall_prev = 1'b0;
      end else if (bus.o_tvalid && !bus.o_tready) begin
        chk("stall_i_tready", 32'(bus.i_tready), 32'd0);
        if (stall_prev) chk("stall_hold", 32'(bus.o_tdata), 32'(held));
        held = bus.o_tdata;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Driver
  initial begin
    int guard;
    reset        = 1'b1;
    clear        = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.o_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_tvalid", 32'(bus.o_tvalid), 32'd0);
    chk("rst_o_tdata", 32'(bus.o_tdata), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    chk("rst_i_tready", 32'(bus.i_tready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Ramp: all outputs 1
    for (int n = 0; n < 30; n++) send(IW'(n < 17 ? n + 1 : 17));

    // Ramp cleared at sample 8 while output is valid, then restarted
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) send(IW'(n + 1));
    cycle(1'b1, IW'(9), 1'b1, 1'b1);
    for (int n = 0; n < 30; n++) send(IW'(n < 17 ? n + 1 : 17));

    // Impulse
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 40; n++) send(IW'(n < 17 ? 5 : 0));

    // Explicit four-cycle backpressure
    cycle(1'b0, '0, 1'b1, 1'b1);
    send(IW'(1));
    send(IW'(2));
    repeat (4) cycle(1'b1, IW'(3), 1'b0, 1'b0);
    for (int n = 3; n < 20; n++) send(IW'(n < 17 ? n : 17));

    // Range error on first sample, sticky afterwards, cleared by clear
    cycle(1'b0, '0, 1'b1, 1'b1);
    send(IW'(32'h0000FFFF));
    for (int k = 1; k < 6; k++) send(IW'(32'h0000FFFF + k));
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Most negative sample through the integrator
    for (int n = 0; n < 40; n++) send(integ(-32768));

    // Random in-range samples with random backpressure and idles
    cycle(1'b0, '0, 1'b1, 1'b1);
    ready_pct = 60;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, ready_gen(), 1'b0);
      send(integ(int'($urandom_range(0, 65535)) - 32768));
    end

    // Async reset mid-stream drops held output; then fully random sums
    do_reset();
    ready_pct = 50;
    for (int n = 0; n < 100; n++) send(IW'($urandom));

    // Reset again and confirm a clean ramp
    do_reset();
    ready_pct = 100;
    for (int n = 0; n < 20; n++) send(IW'(n < 17 ? n + 1 : 17));

    // Drain
    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/direct_bounded_differentiator.md
DIRECT_BOUNDED_DIFFERENTIATOR -- requirements
Module: direct_bounded_differentiator

Interface
REQ-001 Parameter WIDTH, default 16, width of the reconstructed output sample (signed, two's complement).
REQ-002 Parameter SIZE, default 17, window length m+1 of the bounded integrator being inverted (SIZE >= 2).
REQ-003 Derived width IWIDTH = WIDTH+$clog2(SIZE+1), internal only, not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 clear  input  1  synchronous, active-high; same effect as reset at the next rising edge.
REQ-007 i_tdata  input  IWIDTH  signed windowed sum y[n].
REQ-008 i_tvalid  input  1  i_tdata valid.
REQ-009 i_tready  output  1  block accepts i_tdata this cycle.
REQ-010 o_tdata  output  WIDTH  signed reconstructed sample x[n].
REQ-011 o_tvalid  output  1  o_tdata valid.
REQ-012 o_tready  input  1  downstream accepts o_tdata.
REQ-013 range_err  output  1  sticky flag: a reconstructed value did not fit in WIDTH signed bits.

Function
REQ-014 Block SHALL compute x[n] = y[n] - y[n-1] + x[n-SIZE], the exact inverse of y[n] = x[n]+...+x[n-SIZE+1].
REQ-015 Arithmetic SHALL be IWIDTH-bit modulo 2^IWIDTH (wrap, no saturation); intermediate d = y[n]-y[n-1] wraps likewise.
REQ-016 History SHALL hold the last SIZE full IWIDTH-bit results x[n-1]..x[n-SIZE], all zero after reset/clear.
REQ-017 Previous-input register y[n-1] SHALL be zero after reset/clear.
REQ-018 A transfer occurs when i_tvalid & i_tready; only then SHALL history shift, y[n-1] update, and a new result load.
REQ-019 i_tready SHALL equal ~o_tvalid | o_tready (single output stage, no combinational path from i_tvalid to o_tvalid).
REQ-020 Latency SHALL be exactly 1 cycle: result of an input accepted at edge k is on o_tdata with o_tvalid=1 after edge k.
REQ-021 o_tvalid SHALL clear at an edge where o_tready=1 and no new input is accepted; it SHALL stay 1 when both occur.
REQ-022 While o_tvalid=1 and o_tready=0, o_tdata SHALL hold stable and no internal state SHALL change.
REQ-023 Throughput SHALL be one sample per cycle under continuous i_tvalid and o_tready.
REQ-024 o_tdata SHALL be the low WIDTH bits of the IWIDTH result.
REQ-025 range_err SHALL set at the output-load edge if result bits [IWIDTH-1:WIDTH-1] are not all equal; it stays set until reset/clear.
REQ-026 History SHALL store the full IWIDTH result, not the truncated output, so a range error does not corrupt later samples.
REQ-027 When clear and a transfer coincide, clear SHALL win; the input is discarded.

Reset
REQ-028 On reset assertion (asynchronous) or clear (synchronous): o_tvalid=0, o_tdata=0, range_err=0, history=0, y[n-1]=0; i_tready=1 thereafter.
REQ-029 Reset mid-stream SHALL drop any held output; the first sample after release is treated as n=0.

Verification (WIDTH=16, SIZE=17, IWIDTH=21)
REQ-030 Ramp: y = 1,2,...,17,17,17,... with o_tready=1 -> o_tdata = 1 every sample, o_tvalid 1 cycle after each input, range_err=0.
REQ-031 Impulse: y = 5 for n=0..16 then 0 -> o_tdata = 5,0,...,0, and n=17 outputs 0 (0-5+5).
REQ-032 Backpressure: o_tready=0 for 4 cycles with o_tvalid=1 -> i_tready=0, o_tdata unchanged; on release, next sample follows with no loss or duplication.
REQ-033 Range error: first input y=21'h00FFFF (65535) -> o_tdata=16'hFFFF, range_err=1; subsequent valid sums keep range_err=1 until clear.
REQ-034 Negative/wrap: x = -32768 constant fed through a reference integrator -> every o_tdata = 16'h8000, range_err=0.
REQ-035 Clear at sample 8 of the ramp while o_tvalid=1 -> next edge o_tvalid=0, range_err=0; restarted ramp from y=1 reproduces REQ-030.
